// File: rtl/updown_counter_mod.sv
// Parametrised modulo up/down counter with parallel load, wrap/saturate mode,
// combinational terminal count and registered overflow/underflow pulses.
module updown_counter_mod #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX      = 255,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             udf
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic             SAT_V  = (SATURATE != 0);

  logic [WIDTH-1:0] count_nxt;
  logic             ovf_nxt;
  logic             udf_nxt;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (count == MAX_V);
  assign at_zero = (count == '0);

  // Cascade-friendly terminal count: high in the cycle before a boundary edge.
  assign tc = en & ((up & at_max) | (~up & at_zero));

  // Next-state: load beats count; boundaries wrap modulo MAX+1 or hold.
  always_comb begin
    count_nxt = count;
    ovf_nxt   = 1'b0;
    udf_nxt   = 1'b0;
    if (load) begin
      count_nxt = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          ovf_nxt   = 1'b1;
          count_nxt = SAT_V ? MAX_V : '0;
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          udf_nxt   = 1'b1;
          count_nxt = SAT_V ? '0 : MAX_V;
        end else begin
          count_nxt = count - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      count <= count_nxt;
      ovf   <= ovf_nxt;
      udf   <= udf_nxt;
    end
  end

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench for updown_counter_mod: wrap (4b/MAX=9), saturate (4b/MAX=9)
// and full-range (8b/MAX=255) instances driven from one shared stimulus bus.
module tb_updown_counter_mod;

  logic       clk = 1'b0;
  logic       rst, en, up, load;
  logic [7:0] load_val;

  logic [3:0] a_count, s_count;
  logic [7:0] w_count;
  logic       a_tc, a_ovf, a_udf;
  logic       s_tc, s_ovf, s_udf;
  logic       w_tc, w_ovf, w_udf;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  updown_counter_mod #(.WIDTH(4), .MAX(9), .SATURATE(0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val[3:0]),
    .count(a_count), .tc(a_tc), .ovf(a_ovf), .udf(a_udf));

  updown_counter_mod #(.WIDTH(4), .MAX(9), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val[3:0]),
    .count(s_count), .tc(s_tc), .ovf(s_ovf), .udf(s_udf));

  updown_counter_mod #(.WIDTH(8), .MAX(255), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(w_count), .tc(w_tc), .ovf(w_ovf), .udf(w_udf));

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic e, input logic u,
                       input logic l, input logic [7:0] lv);
    rst = r; en = e; up = u; load = l; load_val = lv;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 1, 8'd5);
    edge_step();
    edge_step();
    tests++; if (a_count !== 4'd0 || a_ovf !== 1'b0 || a_udf !== 1'b0) begin failed++;
      $display("FAIL reset_a count=%0d ovf=%b udf=%b expected 0 0 0", a_count, a_ovf, a_udf); end
    tests++; if (s_count !== 4'd0 || s_ovf !== 1'b0 || s_udf !== 1'b0) begin failed++;
      $display("FAIL reset_s count=%0d ovf=%b udf=%b expected 0 0 0", s_count, s_ovf, s_udf); end
    tests++; if (w_count !== 8'd0 || w_ovf !== 1'b0 || w_udf !== 1'b0) begin failed++;
      $display("FAIL reset_w count=%0d ovf=%b udf=%b expected 0 0 0", w_count, w_ovf, w_udf); end
  endtask

  task automatic test_wrap_up();
    drive(0, 1, 1, 0, 8'd0);
    for (int i = 0; i <= 12; i++) begin
      tests++; if (a_count !== 4'(i % 10) || a_tc !== (i % 10 == 9) || a_ovf !== (i == 10)) begin failed++;
        $display("FAIL wrap_up[%0d] count=%0d tc=%b ovf=%b expected %0d %b %b",
                 i, a_count, a_tc, a_ovf, i % 10, (i % 10 == 9), (i == 10)); end
      tests++; if (a_udf !== 1'b0) begin failed++;
        $display("FAIL wrap_up_udf[%0d] udf=%b expected 0", i, a_udf); end
      if (i < 12) edge_step();
    end
  endtask

  task automatic test_wrap_down();
    logic [3:0] exp_c [4] = '{4'd0, 4'd9, 4'd8, 4'd7};
    logic       exp_u [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic       exp_t [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    drive(1, 0, 0, 0, 8'd0);
    edge_step();
    drive(0, 1, 0, 0, 8'd0);
    for (int i = 0; i < 4; i++) begin
      tests++; if (a_count !== exp_c[i] || a_udf !== exp_u[i] || a_tc !== exp_t[i] || a_ovf !== 1'b0) begin failed++;
        $display("FAIL wrap_down[%0d] count=%0d udf=%b tc=%b ovf=%b expected %0d %b %b 0",
                 i, a_count, a_udf, a_tc, a_ovf, exp_c[i], exp_u[i], exp_t[i]); end
      if (i < 3) edge_step();
    end
  endtask

  task automatic test_saturate();
    drive(0, 0, 1, 1, 8'd8);
    edge_step();
    drive(0, 1, 1, 0, 8'd0);
    tests++; if (s_count !== 4'd8 || s_tc !== 1'b0) begin failed++;
      $display("FAIL sat_load count=%0d tc=%b expected 8 0", s_count, s_tc); end
    for (int i = 1; i <= 4; i++) begin
      edge_step();
      tests++; if (s_count !== 4'd9 || s_ovf !== (i > 1) || s_udf !== 1'b0 || s_tc !== 1'b1) begin failed++;
        $display("FAIL sat_up[%0d] count=%0d ovf=%b udf=%b tc=%b expected 9 %b 0 1",
                 i, s_count, s_ovf, s_udf, s_tc, (i > 1)); end
    end
    drive(0, 1, 0, 0, 8'd0);
    edge_step();
    tests++; if (s_count !== 4'd8 || s_ovf !== 1'b0 || s_udf !== 1'b0) begin failed++;
      $display("FAIL sat_down count=%0d ovf=%b udf=%b expected 8 0 0", s_count, s_ovf, s_udf); end
    drive(0, 0, 0, 1, 8'd0);
    edge_step();
    drive(0, 1, 0, 0, 8'd0);
    edge_step();
    tests++; if (s_count !== 4'd0 || s_udf !== 1'b1 || s_ovf !== 1'b0) begin failed++;
      $display("FAIL sat_floor count=%0d udf=%b ovf=%b expected 0 1 0", s_count, s_udf, s_ovf); end
  endtask

  task automatic test_load();
    drive(0, 0, 1, 1, 8'd13);
    edge_step();
    tests++; if (a_count !== 4'd9 || s_count !== 4'd9) begin failed++;
      $display("FAIL load_clamp a=%0d s=%0d expected 9 9", a_count, s_count); end
    // Loading at the boundary with en high must not raise a flag.
    drive(0, 1, 1, 1, 8'd9);
    edge_step();
    tests++; if (a_count !== 4'd9 || a_ovf !== 1'b0 || a_udf !== 1'b0) begin failed++;
      $display("FAIL load_max_en count=%0d ovf=%b udf=%b expected 9 0 0", a_count, a_ovf, a_udf); end
    drive(0, 1, 1, 1, 8'd3);
    edge_step();
    tests++; if (a_count !== 4'd3 || a_ovf !== 1'b0 || a_udf !== 1'b0) begin failed++;
      $display("FAIL load_en count=%0d ovf=%b udf=%b expected 3 0 0", a_count, a_ovf, a_udf); end
    drive(0, 0, 1, 0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      edge_step();
      tests++; if (a_count !== 4'd3 || a_tc !== 1'b0 || a_ovf !== 1'b0) begin failed++;
        $display("FAIL idle[%0d] count=%0d tc=%b ovf=%b expected 3 0 0", i, a_count, a_tc, a_ovf); end
    end
    drive(0, 0, 1, 0, 8'd0);
    load_val = 8'd0; load = 1'b1; #1;
    edge_step();
    drive(0, 0, 1, 0, 8'd0);
    tests++; if (a_tc !== 1'b0 || a_count !== 4'd0) begin failed++;
      $display("FAIL tc_en_low count=%0d tc=%b expected 0 0", a_count, a_tc); end
  endtask

  task automatic test_reset_mid();
    drive(0, 0, 1, 1, 8'd6);
    edge_step();
    drive(1, 1, 1, 1, 8'd2);
    edge_step();
    tests++; if (a_count !== 4'd0 || a_ovf !== 1'b0 || a_udf !== 1'b0) begin failed++;
      $display("FAIL rst_over_load count=%0d ovf=%b udf=%b expected 0 0 0", a_count, a_ovf, a_udf); end
    drive(0, 1, 1, 0, 8'd0);
    edge_step();
    tests++; if (a_count !== 4'd1) begin failed++;
      $display("FAIL rst_then_up count=%0d expected 1", a_count); end
    drive(1, 0, 0, 0, 8'd0);
    edge_step();
    drive(0, 1, 0, 0, 8'd0);
    edge_step();
    tests++; if (a_count !== 4'd9 || a_udf !== 1'b1) begin failed++;
      $display("FAIL rst_then_down count=%0d udf=%b expected 9 1", a_count, a_udf); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_w [3] = '{8'd255, 8'd0, 8'd1};
    logic       exp_o [3] = '{1'b0, 1'b1, 1'b0};
    drive(0, 0, 1, 1, 8'd254);
    edge_step();
    drive(0, 1, 1, 0, 8'd0);
    for (int i = 0; i < 3; i++) begin
      edge_step();
      tests++; if (w_count !== exp_w[i] || w_ovf !== exp_o[i] || w_udf !== 1'b0) begin failed++;
        $display("FAIL wide_up[%0d] count=%0d ovf=%b udf=%b expected %0d %b 0",
                 i, w_count, w_ovf, w_udf, exp_w[i], exp_o[i]); end
      if (i == 0) begin
        tests++; if (w_tc !== 1'b1) begin failed++;
          $display("FAIL wide_tc tc=%b expected 1", w_tc); end
      end
    end
    // Direction flips every edge with no bubble.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, (i % 2 == 1), 0, 8'd0);
      edge_step();
      tests++; if (w_count !== 8'(i % 2) || w_ovf !== 1'b0 || w_udf !== 1'b0) begin failed++;
        $display("FAIL toggle[%0d] count=%0d ovf=%b udf=%b expected %0d 0 0",
                 i, w_count, w_ovf, w_udf, i % 2); end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_val = 8'd0;
    #2;
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_load();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
